// File: rtl/mux_bus_arbiter_if.sv
// Requester handshakes plus bus strobes for the two-requester multiplexed-bus master.
// The shared ad bus is a separate inout port on the arbiter.
interface mux_bus_arbiter_if;
  logic       req0;
  logic       we0;
  logic [7:0] addr0;
  logic [7:0] wdata0;
  logic       gnt0;
  logic       done0;

  logic       req1;
  logic       we1;
  logic [7:0] addr1;
  logic [7:0] wdata1;
  logic       gnt1;
  logic       done1;

  logic [7:0] rdata;
  logic       busy;
  logic       ale;
  logic       rd_n;
  logic       wr_n;

  modport master (
    input  req0, we0, addr0, wdata0,
    input  req1, we1, addr1, wdata1,
    output gnt0, done0, gnt1, done1,
    output rdata, busy, ale, rd_n, wr_n
  );

  modport slave (
    output req0, we0, addr0, wdata0,
    output req1, we1, addr1, wdata1,
    input  gnt0, done0, gnt1, done1,
    input  rdata, busy, ale, rd_n, wr_n
  );
endinterface

// File: rtl/mux_bus_arbiter.sv
// Round-robin two-requester master for the 8-bit multiplexed ad/ale/rd_n/wr_n memory bus.
// One cycle at a time: IDLE (grant), T1 (address), T2/T3 (strobe), TURN turnaround cycles.
module mux_bus_arbiter #(
  parameter int unsigned TURN = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  mux_bus_arbiter_if.master     bus,
  inout  wire  [7:0]            ad
);

  if (TURN < 1 || TURN > 15) begin : gen_turn_range
    $error("TURN must be in 1..15");
  end

  localparam logic [3:0] TurnM1 = 4'(TURN - 1);

  typedef enum logic [2:0] {StIdle, StT1, StT2, StT3, StTa} state_e;

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       rr_q;
  logic       owner_q;
  logic       we_q;
  logic [7:0] addr_q;
  logic [7:0] wdata_q;
  logic [7:0] rdata_q;

  logic       any_req;
  logic       win;
  logic       take;
  logic       strobe;
  logic       ad_oe;
  logic [7:0] ad_out;
  logic       first_ta;

  // Single requester wins outright; on a tie the one that did not win last time goes.
  assign any_req = bus.req0 | bus.req1;
  assign win     = (bus.req0 & bus.req1) ? ~rr_q : bus.req1;
  assign take    = (state_q == StIdle) & any_req;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      StIdle: if (any_req) state_d = StT1;
      StT1:   state_d = StT2;
      StT2:   state_d = StT3;
      StT3: begin
        state_d = StTa;
        cnt_d   = TurnM1;
      end
      StTa: begin
        if (cnt_q == 4'd0) state_d = StIdle;
        else               cnt_d   = cnt_q - 4'd1;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      rr_q    <= 1'b1;
      owner_q <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= 8'h00;
      wdata_q <= 8'h00;
      rdata_q <= 8'h00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (take) begin
        owner_q <= win;
        rr_q    <= win;
        we_q    <= win ? bus.we1    : bus.we0;
        addr_q  <= win ? bus.addr1  : bus.addr0;
        wdata_q <= win ? bus.wdata1 : bus.wdata0;
      end
      if (state_q == StT3 && !we_q) rdata_q <= ad;
    end
  end

  // The counter still holds its load value only in the first turnaround cycle.
  assign first_ta = (state_q == StTa) && (cnt_q == TurnM1);

  assign strobe = (state_q == StT2) || (state_q == StT3);
  assign ad_oe  = (state_q == StT1) || (strobe && we_q);
  assign ad_out = (state_q == StT1) ? addr_q : wdata_q;
  assign ad     = ad_oe ? ad_out : 8'hzz;

  assign bus.gnt0  = take & ~rst & ~win;
  assign bus.gnt1  = take & ~rst & win;
  assign bus.done0 = first_ta & ~owner_q;
  assign bus.done1 = first_ta & owner_q;
  assign bus.rdata = rdata_q;
  assign bus.busy  = (state_q != StIdle);
  assign bus.ale   = (state_q == StT1);
  assign bus.rd_n  = ~(strobe & ~we_q);
  assign bus.wr_n  = ~(strobe & we_q);

  strobe_exclusive_a: assert property (@(posedge clk) disable iff (rst)
    !(!bus.rd_n && !bus.wr_n));
  no_drive_during_read_a: assert property (@(posedge clk) disable iff (rst)
    !(ad_oe && !bus.rd_n));

endmodule

// File: doc/mux_bus_arbiter.md
Name: mux_bus_arbiter

Overview:
- Two-requester bus master for the 8-bit multiplexed address/data bus (ad, ale, rd_n, wr_n) used by the PC test memories.
- Arbitrates between requester 0 and requester 1 (round-robin).
- Sequences one bus cycle at a time in the fixed T1/T2/T3 format the memory slaves expect, then returns read data and a done pulse to the winning requester.

Parameters:
- TURN, 1, number of turnaround cycles after T3 (legal 1..15); bus idle, no ALE.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous reset, active-high
- req0  input  1  requester 0 wants a bus cycle
- we0  input  1  requester 0: 1 = write, 0 = read
- addr0  input  8  requester 0 address
- wdata0  input  8  requester 0 write data
- gnt0  output  1  one-cycle pulse: requester 0 request accepted, inputs captured
- done0  output  1  one-cycle pulse: requester 0 cycle complete
- req1, we1, addr1, wdata1, gnt1, done1  as above for requester 1
- rdata  output  8  read data, valid in the done cycle, held until next read completes
- busy  output  1  high in every state except IDLE
- ale  output  1  address latch enable to bus
- rd_n  output  1  read strobe, active-low
- wr_n  output  1  write strobe, active-low
- ad  inout  8  multiplexed address/data bus, tristated when not driven

Behaviour:
- Reset (synchronous, rst=1 at rising edge):
  - state = IDLE, rr pointer = 1 (requester 0 wins the first tie), rdata = 0.
  - ale = 0, rd_n = wr_n = 1, ad = Z.
  - gnt/done = 0; busy = 0.
- States: IDLE, T1, T2, T3, TA. Bus outputs are Moore, decoded from state plus the captured we/addr/wdata.
- IDLE:
  - Strobes inactive, ad = Z.
  - If any req is high: select winner; gnt of winner = 1 (combinational, this cycle only).
  - At the clock edge, capture we/addr/wdata of the winner and owner id; next state = T1.
- Arbitration: only one request → it wins. Both requesting → the one not equal to the rr pointer wins. rr pointer := winner at grant.
- T1: ale = 1, ad = addr_q, rd_n = wr_n = 1. Next state = T2.
- T2:
  - ale = 0.
  - Read: rd_n = 0, ad = Z.
  - Write: wr_n = 0, ad = wdata_q.
  - Next state = T3.
- T3:
  - Same strobes and drive as T2.
  - Read: rdata := ad sampled at the T3→TA edge.
  - Next state = TA; load turnaround counter with TURN-1.
- TA:
  - Strobes inactive, ad = Z.
  - done of owner = 1 in the first TA cycle only.
  - Counter decrements each cycle; at 0, next state = IDLE.
- Strobe widths:
  - ALE exactly 1 cycle.
  - rd_n/wr_n exactly 2 cycles (T2, T3); never both low.
  - ad never driven while rd_n = 0.
- Throughput: back-to-back minimum spacing between gnt pulses = 4+TURN cycles (IDLE, T1, T2, T3, TA×TURN).
- Request changes:
  - req/addr/we/wdata changes after gnt have no effect on the cycle in progress.
  - A requester holding req after done is granted again subject to round-robin.
- Write cycles leave rdata unchanged.
- Reset mid-cycle (any state): next cycle is IDLE with all outputs at reset values. The aborted requester receives no done.
- X-safety: with no requests, the block stays in IDLE indefinitely with ad = Z.

Test Plan:
- Read: req0=1, we0=0, addr0=0x10, test memory slave on bus (returns 0x23) → gnt0 at cycle 0; ale=1 and ad=0x10 at cycle 1; rd_n=0 at cycles 2–3; done0 at cycle 4 with rdata=0x23; busy high cycles 1–4.
- Write: req1=1, we1=1, addr1=0x40, wdata1=0x5A → ad=0x40 with ale at T1; ad=0x5A and wr_n=0 at T2–T3; slave write_done seen at T3; done1 at TA; rdata unchanged.
- Contention: req0 and req1 held high continuously from reset → grant order 0,1,0,1; gnt spacing exactly 5 cycles (TURN=1); no cycle overlap.
- Reset in T2 of a read: rst=1 at T2 → next cycle rd_n=1, ad=Z, ale=0, busy=0; no done0; the next request proceeds normally.
- TURN=3: single read → done at first TA cycle; next gnt no earlier than 7 cycles after the previous one; ad=Z and strobes inactive throughout TA.
- Bus-conflict check: across all of the above, assert ad is never driven by the arbiter while rd_n=0, and rd_n and wr_n are never both 0.
